ghrd_reset_sequencer: RTL and testbench

Staged reset controller for the 10M50 GHRD SoC subsystem. It synchronizes the board reset and qualifies PLL lock and, optionally, memory-interface calibration. It then releases peripheral reset before CPU reset, with a programmable gap between them. It also re-sequences on PLL lock loss or a CPU-issued soft reset, and sits between the top-level pins and the subsystem's `reset_reset_n` inputs.

---
 rtl/ghrd_reset_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ghrd_reset_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghrd_reset_sequencer.sv
// Staged reset sequencer for the 10M50 GHRD subsystem: board-reset sync, PLL-lock qualification,
// then peripheral-before-CPU release. Define GHRD_RSTSEQ_INIT_WAIT_EN to add the memory init/calibration wait.

module ghrd_reset_sequencer_chk (
  input logic       clk_50,
  input logic       fpga_reset_n,
  input logic       periph_reset_n,
  input logic       cpu_reset_n,
  input logic [2:0] seq_state,
  input logic       fault
);

  a_cpu_after_periph: assert property (@(posedge clk_50) disable iff (!fpga_reset_n)
    cpu_reset_n |-> periph_reset_n);

  a_fault_holds_reset: assert property (@(posedge clk_50) disable iff (!fpga_reset_n)
    fault |-> (!periph_reset_n && !cpu_reset_n));

  a_legal_state: assert property (@(posedge clk_50) disable iff (!fpga_reset_n)
    seq_state != 3'd7);

endmodule

module ghrd_reset_sequencer #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned INIT_TIMEOUT_CYCLES = 1048575,
  parameter int unsigned STAGE_GAP_CYCLES    = 16,
  parameter int unsigned SOFT_HOLD_CYCLES    = 64,
  parameter int unsigned CNT_W               = 20
) (
  input  logic       clk_50,
  input  logic       fpga_reset_n,
  input  logic       pll_locked,
  input  logic       init_done,
  input  logic       cal_fail,
  input  logic       sw_reset_req,
  output logic       periph_reset_n,
  output logic       cpu_reset_n,
  output logic [2:0] seq_state,
  output logic       fault,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_STAGE     = 3'd3,
    ST_RUN       = 3'd4,
    ST_SOFT      = 3'd5,
    ST_FAULT     = 3'd6,
    ST_ILLEGAL   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD_CYCLES - 1);
`ifdef GHRD_RSTSEQ_INIT_WAIT_EN
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_TIMEOUT_CYCLES - 1);
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  logic [SYNC_STAGES-1:0] rst_sync_r;
  logic [SYNC_STAGES-1:0] lock_sync_r;
  logic                   rst_done_s;
  logic                   lock_s;
  logic                   sw_prev_r;
  logic                   sw_rise_s;

  state_t                 state_r;
  state_t                 state_nx;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_step_s;
  logic [CNT_W-1:0]       cnt_nx;
  logic                   ll_inc_s;
  logic                   periph_nx;
  logic                   cpu_nx;
  logic                   fault_nx;

  logic                   periph_reset_n_r;
  logic                   cpu_reset_n_r;
  logic                   fault_r;
  logic [7:0]             lock_loss_cnt_r;

  // Release of the board reset is re-timed onto clk_50; assertion stays asynchronous.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      rst_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      rst_sync_r <= {rst_sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // PLL lock synchronizer and soft-request edge register.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      lock_sync_r <= {SYNC_STAGES{1'b0}};
      sw_prev_r   <= 1'b0;
    end else begin
      lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], pll_locked};
      sw_prev_r   <= sw_reset_req;
    end
  end

  assign rst_done_s = rst_sync_r[SYNC_STAGES-1];
  assign lock_s     = lock_sync_r[SYNC_STAGES-1];
  assign sw_rise_s  = sw_reset_req & ~sw_prev_r;

`ifdef GHRD_RSTSEQ_INIT_WAIT_EN
  logic [SYNC_STAGES-1:0] init_sync_r;
  logic [SYNC_STAGES-1:0] cal_sync_r;
  logic                   init_s;
  logic                   cal_s;

  // Memory init / calibration status synchronizers.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      init_sync_r <= {SYNC_STAGES{1'b0}};
      cal_sync_r  <= {SYNC_STAGES{1'b0}};
    end else begin
      init_sync_r <= {init_sync_r[SYNC_STAGES-2:0], init_done};
      cal_sync_r  <= {cal_sync_r[SYNC_STAGES-2:0], cal_fail};
    end
  end

  assign init_s = init_sync_r[SYNC_STAGES-1];
  assign cal_s  = cal_sync_r[SYNC_STAGES-1];
`else
  logic unused_init_inputs_s;
  assign unused_init_inputs_s = init_done ^ cal_fail;
`endif

  // Next-state and shared-counter step; the counter is forced to zero on any transition below.
  always_comb begin
    state_nx   = state_r;
    cnt_step_s = cnt_r;
    ll_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rst_done_s) begin
          state_nx = ST_WAIT_LOCK;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_step_s = CNT_ZERO;
        end else if (cnt_r == LOCK_LAST) begin
`ifdef GHRD_RSTSEQ_INIT_WAIT_EN
          state_nx = ST_WAIT_INIT;
`else
          state_nx = ST_STAGE;
`endif
        end else begin
          cnt_step_s = cnt_r + CNT_ONE;
        end
      end
`ifdef GHRD_RSTSEQ_INIT_WAIT_EN
      ST_WAIT_INIT: begin
        if (cal_s) begin
          state_nx = ST_FAULT;
        end else if (init_s) begin
          state_nx = ST_STAGE;
        end else if (cnt_r == INIT_LAST) begin
          state_nx = ST_FAULT;
        end else if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
        end else begin
          cnt_step_s = cnt_r + CNT_ONE;
        end
      end
      ST_FAULT: begin
        state_nx = ST_FAULT;
      end
`endif
      ST_STAGE: begin
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
        end else if (cnt_r == GAP_LAST) begin
          state_nx = ST_RUN;
        end else begin
          cnt_step_s = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
          ll_inc_s = 1'b1;
        end else if (sw_rise_s) begin
          state_nx = ST_SOFT;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_SOFT: begin
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
        end else if (cnt_r == SOFT_LAST) begin
          state_nx = ST_STAGE;
        end else begin
          cnt_step_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign cnt_nx    = (state_nx != state_r) ? CNT_ZERO : cnt_step_s;
  // Outputs are decoded from the next state so they change on the same edge as the state.
  assign periph_nx = (state_nx == ST_STAGE) || (state_nx == ST_RUN);
  assign cpu_nx    = (state_nx == ST_RUN);
`ifdef GHRD_RSTSEQ_INIT_WAIT_EN
  assign fault_nx  = fault_r | (state_nx == ST_FAULT);
`else
  assign fault_nx  = 1'b0;
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      state_r          <= ST_IDLE;
      cnt_r            <= CNT_ZERO;
      periph_reset_n_r <= 1'b0;
      cpu_reset_n_r    <= 1'b0;
      fault_r          <= 1'b0;
      lock_loss_cnt_r  <= 8'd0;
    end else begin
      state_r          <= state_nx;
      cnt_r            <= cnt_nx;
      periph_reset_n_r <= periph_nx;
      cpu_reset_n_r    <= cpu_nx;
      fault_r          <= fault_nx;
      if (ll_inc_s) begin
        lock_loss_cnt_r <= sat_inc8(lock_loss_cnt_r);
      end
    end
  end

  assign periph_reset_n = periph_reset_n_r;
  assign cpu_reset_n    = cpu_reset_n_r;
  assign seq_state      = state_r;
  assign fault          = fault_r;
  assign lock_loss_cnt  = lock_loss_cnt_r;

  ghrd_reset_sequencer_chk u_chk (
    .clk_50         (clk_50),
    .fpga_reset_n   (fpga_reset_n),
    .periph_reset_n (periph_reset_n_r),
    .cpu_reset_n    (cpu_reset_n_r),
    .seq_state      (state_r),
    .fault          (fault_r)
  );

endmodule

// File: tb/tb_ghrd_reset_sequencer.sv
// Scoreboard bench for ghrd_reset_sequencer: every output change is matched against a queued
// expected {state, resets, fault, count} tuple and the clock cycle it should appear on.
module tb_ghrd_reset_sequencer;

  logic       clk_50;
  logic       fpga_reset_n;
  logic       pll_locked;
  logic       init_done;
  logic       cal_fail;
  logic       sw_reset_req;
  logic       periph_reset_n;
  logic       cpu_reset_n;
  logic [2:0] seq_state;
  logic       fault;
  logic [7:0] lock_loss_cnt;

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  ghrd_reset_sequencer #(
    .SYNC_STAGES         (2),
    .LOCK_STABLE_CYCLES  (8),
    .INIT_TIMEOUT_CYCLES (100),
    .STAGE_GAP_CYCLES    (4),
    .SOFT_HOLD_CYCLES    (6),
    .CNT_W               (20)
  ) dut (
    .clk_50         (clk_50),
    .fpga_reset_n   (fpga_reset_n),
    .pll_locked     (pll_locked),
    .init_done      (init_done),
    .cal_fail       (cal_fail),
    .sw_reset_req   (sw_reset_req),
    .periph_reset_n (periph_reset_n),
    .cpu_reset_n    (cpu_reset_n),
    .seq_state      (seq_state),
    .fault          (fault),
    .lock_loss_cnt  (lock_loss_cnt)
  );

  typedef struct {
    logic [13:0] tup;
    int          at;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  int   ncyc   = 0;

  always @(posedge clk_50) ncyc <= ncyc + 1;

  // Monitor: each change of the observed tuple consumes one expectation.
  logic [13:0] prev_tup = 14'd0;
  bit          first_smp = 1'b1;
  always @(negedge clk_50) begin
    logic [13:0] cur;
    exp_t        e;
    cur = {seq_state, periph_reset_n, cpu_reset_n, fault, lock_loss_cnt};
    if (first_smp || cur !== prev_tup) begin
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_change: got st=%0d prst=%b crst=%b fault=%b llc=%0d cyc=%0d, want no change",
                 cur[13:11], cur[10], cur[9], cur[8], cur[7:0], ncyc);
      end else begin
        e = sb_q.pop_front();
        if (cur !== e.tup || (e.at >= 0 && e.at != ncyc)) begin
          $display("FAIL %s: got st=%0d prst=%b crst=%b fault=%b llc=%0d cyc=%0d, want st=%0d prst=%b crst=%b fault=%b llc=%0d cyc=%0d",
                   e.name, cur[13:11], cur[10], cur[9], cur[8], cur[7:0], ncyc,
                   e.tup[13:11], e.tup[10], e.tup[9], e.tup[8], e.tup[7:0], e.at);
        end else begin
          passes++;
        end
      end
      prev_tup  = cur;
      first_smp = 1'b0;
    end
  end

  task automatic push(input logic [2:0] st, input logic pr, input logic cr, input logic fl,
                      input logic [7:0] llc, input int at, input string nm);
    exp_t e;
    e.tup  = {st, pr, cr, fl, llc};
    e.at   = at;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Events following lock qualification completing on cycle m.
  task automatic push_relock(input int m, input logic [7:0] llc, input string nm);
`ifdef GHRD_RSTSEQ_INIT_WAIT_EN
    push(3'd2, 1'b0, 1'b0, 1'b0, llc, m,     {nm, "_wait_init"});
    push(3'd3, 1'b1, 1'b0, 1'b0, llc, m + 1, {nm, "_stage"});
    push(3'd4, 1'b1, 1'b1, 1'b0, llc, m + 5, {nm, "_run"});
`else
    push(3'd3, 1'b1, 1'b0, 1'b0, llc, m,     {nm, "_stage"});
    push(3'd4, 1'b1, 1'b1, 1'b0, llc, m + 4, {nm, "_run"});
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by cycle %0d, want finish", ncyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         k;
    int         m;
    logic [7:0] llc_m;
    fpga_reset_n = 1'b1;
    pll_locked   = 1'b1;
    init_done    = 1'b1;
    cal_fail     = 1'b0;
    sw_reset_req = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, -1, "reset_state");
    #1 fpga_reset_n = 1'b0;
    tick(3);

    // Nominal bring-up.
    k = ncyc;
    fpga_reset_n = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0, 8'd0, k + 3, "boot_wait_lock");
    push_relock(k + 11, 8'd0, "boot");
    tick(20);

    // Lock loss in RUN, then a one-sample glitch after 5 good samples.
    m = ncyc;
    pll_locked = 1'b0;
    push(3'd1, 1'b0, 1'b0, 1'b0, 8'd1, m + 3, "lockloss_run");
    push_relock(m + 21, 8'd1, "glitch");
    tick(5);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(20);

    // Soft reset with the request held high for 20 cycles.
    m = ncyc;
    sw_reset_req = 1'b1;
    push(3'd5, 1'b0, 1'b0, 1'b0, 8'd1, m + 1,  "soft_enter");
    push(3'd3, 1'b1, 1'b0, 1'b0, 8'd1, m + 7,  "soft_stage");
    push(3'd4, 1'b1, 1'b1, 1'b0, 8'd1, m + 11, "soft_run");
    tick(20);
    sw_reset_req = 1'b0;
    tick(5);

    // Lock loss on the same edge as a soft-request rising edge.
    m = ncyc;
    pll_locked = 1'b0;
    push(3'd1, 1'b0, 1'b0, 1'b0, 8'd2, m + 3, "lockloss_vs_soft");
    push_relock(m + 15, 8'd2, "coincident");
    tick(2);
    sw_reset_req = 1'b1;
    tick(3);
    pll_locked   = 1'b1;
    sw_reset_req = 1'b0;
    tick(20);

    // Remaining lock losses up to 300 total; the count must saturate at 255.
    llc_m = 8'd2;
    for (int i = 0; i < 298; i++) begin
      llc_m = (llc_m == 8'd255) ? 8'd255 : llc_m + 8'd1;
      m = ncyc;
      pll_locked = 1'b0;
      push(3'd1, 1'b0, 1'b0, 1'b0, llc_m, m + 3, "lockloss_loop");
      push_relock(m + 15, llc_m, "loop");
      tick(5);
      pll_locked = 1'b1;
      tick(20);
    end

`ifdef GHRD_RSTSEQ_INIT_WAIT_EN
    // cal_fail and init_done together: cal_fail wins, fault is sticky.
    m = ncyc;
    init_done    = 1'b0;
    fpga_reset_n = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, m, "reset_from_run");
    tick(2);
    k = ncyc;
    fpga_reset_n = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0, 8'd0, k + 3,  "cal_wait_lock");
    push(3'd2, 1'b0, 1'b0, 1'b0, 8'd0, k + 11, "cal_wait_init");
    push(3'd6, 1'b0, 1'b0, 1'b1, 8'd0, k + 16, "cal_fault");
    tick(13);
    cal_fail  = 1'b1;
    init_done = 1'b1;
    tick(10);
    m = ncyc;
    fpga_reset_n = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, m, "fault_cleared");
    cal_fail  = 1'b0;
    init_done = 1'b0;
    tick(2);

    // init_done never arrives: timeout after 100 cycles in WAIT_INIT.
    k = ncyc;
    fpga_reset_n = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0, 8'd0, k + 3,   "to_wait_lock");
    push(3'd2, 1'b0, 1'b0, 1'b0, 8'd0, k + 11,  "to_wait_init");
    push(3'd6, 1'b0, 1'b0, 1'b1, 8'd0, k + 111, "to_fault");
    tick(115);
    m = ncyc;
    fpga_reset_n = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, m, "timeout_cleared");
    init_done = 1'b1;
    tick(2);

    // Async reset while in STAGE.
    k = ncyc;
    fpga_reset_n = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0, 8'd0, k + 3,  "st_wait_lock");
    push(3'd2, 1'b0, 1'b0, 1'b0, 8'd0, k + 11, "st_wait_init");
    push(3'd3, 1'b1, 1'b0, 1'b0, 8'd0, k + 12, "st_stage");
    tick(13);
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, k + 13, "async_reset_in_stage");
    fpga_reset_n = 1'b0;
`else
    // init_done/cal_fail have no effect when the init wait is compiled out.
    m = ncyc;
    fpga_reset_n = 1'b0;
    cal_fail     = 1'b1;
    init_done    = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, m, "reset_from_run");
    tick(2);
    k = ncyc;
    fpga_reset_n = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0, 8'd0, k + 3,  "nocal_wait_lock");
    push(3'd3, 1'b1, 1'b0, 1'b0, 8'd0, k + 11, "nocal_stage");
    push(3'd4, 1'b1, 1'b1, 1'b0, 8'd0, k + 15, "nocal_run");
    tick(20);
    m = ncyc;
    fpga_reset_n = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, m, "reset_from_run2");
    cal_fail = 1'b0;
    tick(2);

    // Async reset while in STAGE.
    k = ncyc;
    fpga_reset_n = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0, 8'd0, k + 3,  "st_wait_lock");
    push(3'd3, 1'b1, 1'b0, 1'b0, 8'd0, k + 11, "st_stage");
    tick(12);
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, k + 12, "async_reset_in_stage");
    fpga_reset_n = 1'b0;
`endif

    for (int i = 0; i < 200 && sb_q.size() > 0; i++) tick(1);
    tick(3);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      $display("FAIL %s: got no output change, want st=%0d prst=%b crst=%b fault=%b llc=%0d cyc=%0d",
               e.name, e.tup[13:11], e.tup[10], e.tup[9], e.tup[8], e.tup[7:0], e.at);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
